column_scheduler: RTL and testbench



---
 rtl/column_scheduler_if.sv | 29 ++
 rtl/column_scheduler.sv | 159 +++++++++++++++
 tb/tb_column_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/column_scheduler_if.sv
// Signal bundle between the game controls and the column scheduler.
// master = control/stimulus side, slave = column_scheduler.
interface column_scheduler_if #(
    parameter int NUM_COLS = 3,
    parameter int SCORE_W  = 8
);
    // start, correct and game_over are single-cycle pulses sampled on the rising clock
    // edge; every output is driven from registers and changes only after that edge.
    logic                start;
    logic [NUM_COLS-1:0] correct;
    logic [NUM_COLS-1:0] game_over;
    logic [NUM_COLS-1:0] col_reset;
    logic [NUM_COLS-1:0] col_active;
    logic [SCORE_W-1:0]  score;
    logic [2:0]          level;
    logic                playing;
    logic                over;
    logic [1:0]          state_dbg;

    modport master (
        output start, correct, game_over,
        input  col_reset, col_active, score, level, playing, over, state_dbg
    );

    modport slave (
        input  start, correct, game_over,
        output col_reset, col_active, score, level, playing, over, state_dbg
    );
endinterface

// File: rtl/column_scheduler.sv
// Releases the letter columns on a fixed stagger, respawns them on correct answers and
// keeps the saturating score/level. Define HIGH_SCORE_EN to add the sticky high_score output.
module column_scheduler #(
    parameter int NUM_COLS    = 3,
    parameter int SPAWN_GAP   = 4096,
    parameter int SCORE_W     = 8,
    parameter int LEVEL_SHIFT = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    column_scheduler_if.slave  bus
`ifdef HIGH_SCORE_EN
    ,
    output logic [SCORE_W-1:0] high_score
`endif
);

    localparam int CNT_W = $clog2(SPAWN_GAP + 1);
    localparam int IDX_W = $clog2(NUM_COLS + 1);
    localparam int SUM_W = SCORE_W + IDX_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    spawn_cnt;
    logic [IDX_W-1:0]    next_idx;
    logic [NUM_COLS-1:0] released;
    logic [NUM_COLS-1:0] respawn;
    logic [SCORE_W-1:0]  score;
    logic [2:0]          level;

    logic [NUM_COLS-1:0] active;
    logic [NUM_COLS-1:0] valid_go;
    logic [NUM_COLS-1:0] valid_cor;
    logic                launch;
    logic                end_game;
    logic                spawn_pending;
    logic                spawn_fire;
    logic [NUM_COLS-1:0] spawn_onehot;
    logic [IDX_W-1:0]    pop;
    logic [SUM_W-1:0]    sum;
    logic [SCORE_W-1:0]  score_next;
    logic [SCORE_W-1:0]  shifted;
    logic [2:0]          level_next;
    logic [NUM_COLS-1:0] col_reset_w;

    // A column counts as active only when released and not inside its respawn pulse.
    always_comb begin
        active    = (state == ST_RUN) ? (released & ~respawn) : '0;
        valid_go  = bus.game_over & active;
        valid_cor = (|valid_go) ? '0 : (bus.correct & active);
        launch    = (state != ST_RUN) && bus.start;
        end_game  = (state == ST_RUN) && (|valid_go);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start)   state_next = ST_RUN;
            ST_RUN:  if (|valid_go)   state_next = ST_OVER;
            ST_OVER: if (bus.start)   state_next = ST_RUN;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        spawn_pending = next_idx < IDX_W'(NUM_COLS);
        spawn_fire    = spawn_pending && (spawn_cnt == CNT_W'(SPAWN_GAP - 1));
        spawn_onehot  = NUM_COLS'(1) << next_idx;
    end

    // Saturating score update and the level derived from the new score.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            pop = pop + IDX_W'(valid_cor[i]);
        end
        sum = SUM_W'(score) + SUM_W'(pop);
        if (sum > SUM_W'(SCORE_MAX)) begin
            score_next = SCORE_MAX;
        end else begin
            score_next = sum[SCORE_W-1:0];
        end
        shifted = score_next >> LEVEL_SHIFT;
        if (shifted > SCORE_W'(7)) begin
            level_next = 3'd7;
        end else begin
            level_next = shifted[2:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spawn_cnt <= '0;
            next_idx  <= '0;
            released  <= '0;
            respawn   <= '0;
            score     <= '0;
            level     <= '0;
        end else if (launch) begin
            // Column 0 goes live on the cycle after start; the stagger restarts from here.
            spawn_cnt <= '0;
            next_idx  <= IDX_W'(1);
            released  <= NUM_COLS'(1);
            respawn   <= '0;
            score     <= '0;
            level     <= '0;
        end else if (end_game) begin
            respawn   <= '0;
        end else if (state == ST_RUN) begin
            respawn   <= valid_cor;
            score     <= score_next;
            level     <= level_next;
            if (spawn_fire) begin
                released  <= released | spawn_onehot;
                next_idx  <= next_idx + IDX_W'(1);
                spawn_cnt <= '0;
            end else if (spawn_pending) begin
                spawn_cnt <= spawn_cnt + CNT_W'(1);
            end
        end
    end

`ifdef HIGH_SCORE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            high_score <= '0;
        end else if (end_game && (score > high_score)) begin
            high_score <= score;
        end
    end
`endif

    always_comb begin
        col_reset_w    = (state == ST_RUN) ? (~released | respawn) : '1;
        bus.col_reset  = col_reset_w;
        bus.col_active = (state == ST_RUN) ? ~col_reset_w : '0;
        bus.score      = score;
        bus.level      = level;
        bus.playing    = (state == ST_RUN);
        bus.over       = (state == ST_OVER);
        bus.state_dbg  = state;
    end

endmodule

// File: tb/tb_column_scheduler.sv
// Bench for column_scheduler: a vector table for the release schedule and first scores,
// plus hand-written sequences for saturation, game over, restart and async reset.
module tb_column_scheduler;

  localparam int NUM_COLS    = 3;
  localparam int SPAWN_GAP   = 4;
  localparam int SCORE_W     = 8;
  localparam int LEVEL_SHIFT = 4;

  typedef struct packed {
    logic [2:0] col_reset;
    logic [2:0] col_active;
    logic [7:0] score;
    logic [2:0] level;
    logic       playing;
    logic       over;
  } out_t;

  localparam int W = $bits(out_t);

  typedef struct packed {
    logic       st;
    logic [2:0] cor;
    logic [2:0] go;
    out_t       exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  column_scheduler_if #(.NUM_COLS(NUM_COLS), .SCORE_W(SCORE_W)) bus ();

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score;
`endif

  column_scheduler #(
    .NUM_COLS(NUM_COLS),
    .SPAWN_GAP(SPAWN_GAP),
    .SCORE_W(SCORE_W),
    .LEVEL_SHIFT(LEVEL_SHIFT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
`ifdef HIGH_SCORE_EN
    ,
    .high_score(high_score)
`endif
  );

  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int model_score = 0;
  vec_t tbl[16];

  function automatic logic [2:0] lvl(input int s);
    int l;
    l = s >> LEVEL_SHIFT;
    if (l > 7) l = 7;
    return l[2:0];
  endfunction

  function automatic out_t mk(input logic [2:0] cr, input int sc, input logic pl, input logic ov);
    out_t o;
    o.col_reset  = cr;
    o.col_active = pl ? ~cr : 3'b000;
    o.score      = sc[7:0];
    o.level      = lvl(sc);
    o.playing    = pl;
    o.over       = ov;
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o = {bus.col_reset, bus.col_active, bus.score, bus.level, bus.playing, bus.over};
    return o;
  endfunction

  task automatic compare(input string name, input out_t got, input out_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got cr=%b act=%b score=%0d lvl=%0d play=%b over=%b, want cr=%b act=%b score=%0d lvl=%0d play=%b over=%b",
               name, got.col_reset, got.col_active, got.score, got.level, got.playing, got.over,
               want.col_reset, want.col_active, want.score, want.level, want.playing, want.over);
    end
  endtask

  task automatic check_sb(input string name);
    out_t want;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty when output was produced", name);
    end else begin
      want = exp_q.pop_front();
      compare(name, actual(), want);
    end
  endtask

  task automatic check_hs(input string name, input int want);
`ifdef HIGH_SCORE_EN
    total++;
    if (high_score !== want[7:0]) begin
      bad++;
      $display("FAIL %s: high_score got %0d want %0d", name, high_score, want);
    end
`else
    if (name.len() < 0) $display("%s %0d", name, want);
`endif
  endtask

  task automatic drive(input string name, input logic st, input logic [2:0] cor,
                       input logic [2:0] go, input out_t want);
    @(negedge clock);
    bus.start     = st;
    bus.correct   = cor;
    bus.game_over = go;
    exp_q.push_back(want);
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.correct   = 3'b000;
    bus.game_over = 3'b000;
    check_sb(name);
  endtask

  task automatic burst(input logic [2:0] mask);
    model_score = model_score + $countones(mask);
    if (model_score > 255) model_score = 255;
    drive("burst", 1'b0, mask, 3'b000, mk(mask, model_score, 1'b1, 1'b0));
    drive("burst_idle", 1'b0, 3'b000, 3'b000, mk(3'b000, model_score, 1'b1, 1'b0));
  endtask

  task automatic start_game();
    logic [2:0] cr;
    model_score = 0;
    drive("restart", 1'b1, 3'b000, 3'b000, mk(3'b110, 0, 1'b1, 1'b0));
    for (int k = 1; k <= 2 * SPAWN_GAP; k++) begin
      cr = (k < SPAWN_GAP) ? 3'b110 : ((k < 2 * SPAWN_GAP) ? 3'b100 : 3'b000);
      drive("release", 1'b0, 3'b000, 3'b000, mk(cr, 0, 1'b1, 1'b0));
    end
  endtask

  task automatic end_game(input logic [2:0] go);
    drive("game_over", 1'b0, 3'b000, go, mk(3'b111, model_score, 1'b0, 1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{st:1'b1, cor:3'b000, go:3'b000, exp:mk(3'b110, 0, 1'b1, 1'b0)};
    tbl[1]  = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b110, 0, 1'b1, 1'b0)};
    tbl[2]  = '{st:1'b0, cor:3'b100, go:3'b010, exp:mk(3'b110, 0, 1'b1, 1'b0)};
    tbl[3]  = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b110, 0, 1'b1, 1'b0)};
    tbl[4]  = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b100, 0, 1'b1, 1'b0)};
    tbl[5]  = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b100, 0, 1'b1, 1'b0)};
    tbl[6]  = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b100, 0, 1'b1, 1'b0)};
    tbl[7]  = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b100, 0, 1'b1, 1'b0)};
    tbl[8]  = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b000, 0, 1'b1, 1'b0)};
    tbl[9]  = '{st:1'b1, cor:3'b000, go:3'b000, exp:mk(3'b000, 0, 1'b1, 1'b0)};
    tbl[10] = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b000, 0, 1'b1, 1'b0)};
    tbl[11] = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b000, 0, 1'b1, 1'b0)};
    tbl[12] = '{st:1'b0, cor:3'b010, go:3'b000, exp:mk(3'b010, 1, 1'b1, 1'b0)};
    tbl[13] = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b000, 1, 1'b1, 1'b0)};
    tbl[14] = '{st:1'b0, cor:3'b101, go:3'b000, exp:mk(3'b101, 3, 1'b1, 1'b0)};
    tbl[15] = '{st:1'b0, cor:3'b000, go:3'b000, exp:mk(3'b000, 3, 1'b1, 1'b0)};

    bus.start     = 1'b0;
    bus.correct   = 3'b000;
    bus.game_over = 3'b000;
    reset_n       = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    compare("reset", actual(), mk(3'b111, 0, 1'b0, 1'b0));
    check_hs("reset_high", 0);
    @(negedge clock);
    reset_n = 1'b1;

    // IDLE ignores everything but start.
    drive("idle_correct", 1'b0, 3'b111, 3'b000, mk(3'b111, 0, 1'b0, 1'b0));
    drive("idle_go", 1'b0, 3'b000, 3'b111, mk(3'b111, 0, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      drive("idle", 1'b0, 3'b000, 3'b000, mk(3'b111, 0, 1'b0, 1'b0));
    end

    for (int i = 0; i < 16; i++) begin
      drive($sformatf("vec%0d", i), tbl[i].st, tbl[i].cor, tbl[i].go, tbl[i].exp);
    end
    model_score = 3;

    repeat (3) burst(3'b111);
    burst(3'b011);
    drive("triple_from_14", 1'b0, 3'b111, 3'b000, mk(3'b111, 17, 1'b1, 1'b0));
    model_score = 17;
    drive("triple_idle", 1'b0, 3'b000, 3'b000, mk(3'b000, 17, 1'b1, 1'b0));

    repeat (79) burst(3'b111);
    drive("sat_255", 1'b0, 3'b001, 3'b000, mk(3'b001, 255, 1'b1, 1'b0));
    drive("sat_idle", 1'b0, 3'b000, 3'b000, mk(3'b000, 255, 1'b1, 1'b0));
    drive("sat_hold", 1'b0, 3'b001, 3'b000, mk(3'b001, 255, 1'b1, 1'b0));
    drive("sat_hold_idle", 1'b0, 3'b000, 3'b000, mk(3'b000, 255, 1'b1, 1'b0));
    model_score = 255;

    end_game(3'b001);
    drive("over_correct", 1'b0, 3'b111, 3'b000, mk(3'b111, 255, 1'b0, 1'b1));
    drive("over_go", 1'b0, 3'b000, 3'b111, mk(3'b111, 255, 1'b0, 1'b1));

    start_game();
    burst(3'b111);
    burst(3'b011);
    drive("go_beats_correct", 1'b0, 3'b001, 3'b001, mk(3'b111, 5, 1'b0, 1'b1));
    drive("over_hold", 1'b0, 3'b000, 3'b000, mk(3'b111, 5, 1'b0, 1'b1));
    drive("restart_score0", 1'b1, 3'b000, 3'b000, mk(3'b110, 0, 1'b1, 1'b0));
    drive("start_go_tie", 1'b1, 3'b000, 3'b001, mk(3'b111, 0, 1'b0, 1'b1));

    start_game();
    repeat (3) burst(3'b111);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    compare("async_reset", actual(), mk(3'b111, 0, 1'b0, 1'b0));
    check_hs("async_reset_high", 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive("post_reset_idle", 1'b0, 3'b000, 3'b000, mk(3'b111, 0, 1'b0, 1'b0));

    start_game();
    repeat (4) burst(3'b111);
    end_game(3'b010);
    check_hs("high_after_12", 12);
    start_game();
    repeat (2) burst(3'b111);
    burst(3'b001);
    end_game(3'b100);
    check_hs("high_keeps_12", 12);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
